// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into fixed-width LED blinks separated by a fixed gap.
// Events arriving during a blink are queued in a saturating counter and replayed back-to-back.
module led_event_blinker #(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int OFF_CYCLES = 5_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              flush,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic [PEND_W-1:0]   pending_reg, pending_next;
    logic                overflow_reg, overflow_next;
    logic                led_reg, busy_reg;

    // Result of queueing an incoming event while a blink is running.
    logic [PEND_W-1:0]   pending_inc;
    logic                drop_event;

    always_comb begin
        drop_event  = (pending_reg == PEND_MAX);
        pending_inc = drop_event ? pending_reg : pending_reg + 1'b1;
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        pending_next  = pending_reg;
        overflow_next = 1'b0;

        if (flush) begin
            state_next   = IDLE;
            timer_next   = '0;
            pending_next = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (pulse_in) begin
                        state_next = ON;
                        timer_next = ON_LOAD;
                    end
                end
                ON: begin
                    if (timer_reg == '0) begin
                        state_next = GAP;
                        timer_next = OFF_LOAD;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                    if (pulse_in) begin
                        pending_next  = pending_inc;
                        overflow_next = drop_event;
                    end
                end
                GAP: begin
                    if (timer_reg == '0) begin
                        if ((pending_reg != '0) || pulse_in) begin
                            state_next = ON;
                            timer_next = ON_LOAD;
                            // A simultaneous pulse replaces the queued event it consumes.
                            if ((pending_reg != '0) && !pulse_in)
                                pending_next = pending_reg - 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        timer_next = timer_reg - 1'b1;
                        if (pulse_in) begin
                            pending_next  = pending_inc;
                            overflow_next = drop_event;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
            led_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            led_reg      <= (state_next == ON);
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign led_out  = led_reg;
    assign busy     = busy_reg;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_led_event_blinker.sv
// Scoreboard bench for led_event_blinker (ON=4, OFF=3, PEND_W=2): stimulus queues expected
// output events with their cycle stamps, a monitor detects output events and compares them.
module tb_led_event_blinker;

    localparam int EV_PEND  = 0;
    localparam int EV_LRISE = 1;
    localparam int EV_LFALL = 2;
    localparam int EV_BRISE = 3;
    localparam int EV_BFALL = 4;
    localparam int EV_OVF   = 5;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       flush;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int  cyc;
    int  checks;
    int  errors;
    ev_t exp_q[$];

    led_event_blinker #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3),
        .PEND_W    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .flush   (flush),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_PEND:  return "pending_change";
            EV_LRISE: return "led_rise";
            EV_LFALL: return "led_fall";
            EV_BRISE: return "busy_rise";
            EV_BFALL: return "busy_fall";
            EV_OVF:   return "overflow";
            default:  return "unknown";
        endcase
    endfunction

    task automatic ex(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s at cycle %0d (val %0d), expected no event", kname(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                errors++;
                $display("FAIL event: got %s@%0d val %0d, expected %s@%0d val %0d",
                         kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
            end else begin
                $display("ok   %s at cycle %0d val %0d", kname(kind), cyc, val);
            end
        end
    endtask

    // Monitor: output events in a fixed per-cycle order, compared against the scoreboard.
    initial begin : monitor
        logic       pl, pb;
        logic [1:0] pp;
        ev_t        m;
        pl = 1'b0; pb = 1'b0; pp = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pl = 1'b0; pb = 1'b0; pp = '0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    m = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed %s: got nothing by cycle %0d, expected at cycle %0d val %0d",
                             kname(m.kind), cyc, m.cyc, m.val);
                end
                if (pending != pp)       observe(EV_PEND, int'(pending));
                if (led_out && !pl)      observe(EV_LRISE, 0);
                if (!led_out && pl)      observe(EV_LFALL, 0);
                if (busy && !pb)         observe(EV_BRISE, 0);
                if (!busy && pb)         observe(EV_BFALL, 0);
                if (overflow)            observe(EV_OVF, 0);
                pl = led_out; pb = busy; pp = pending;
            end
        end
    end

    // Caller is at the negedge of the first stimulus cycle.
    task automatic run(input logic [31:0] pm, input logic [31:0] fm, input int len);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            pulse_in = pm[i];
            flush    = fm[i];
        end
        @(negedge clk);
        pulse_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc, input int idle);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s drain: got %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (idle) @(negedge clk);
    endtask

    initial begin : stimulus
        int t;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        pulse_in = 1'b0;
        flush    = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_led", int'(led_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_overflow", int'(overflow), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Single pulse: on 4 cycles, off 3, busy 7.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_LFALL, t+5, 0); ex(EV_BFALL, t+8, 0);
        run(32'h1, 32'h0, 1);
        drain("single", 40, 10);

        // Reset in the second ON cycle clears everything at once.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        pulse_in = 1'b1;
        @(negedge clk); pulse_in = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset_led", int'(led_out), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_pending", int'(pending), 0);
        chk("midreset_overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        drain("midreset", 10, 5);

        // Normal blink after the reset release.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_LFALL, t+5, 0); ex(EV_BFALL, t+8, 0);
        run(32'h1, 32'h0, 1);
        drain("after_reset", 40, 10);

        // Three consecutive pulses: three blinks at t+1, t+8, t+15.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_PEND, t+2, 1); ex(EV_PEND, t+3, 2);
        ex(EV_LFALL, t+5, 0);
        ex(EV_PEND, t+8, 1); ex(EV_LRISE, t+8, 0);
        ex(EV_LFALL, t+12, 0);
        ex(EV_PEND, t+15, 0); ex(EV_LRISE, t+15, 0);
        ex(EV_LFALL, t+19, 0); ex(EV_BFALL, t+22, 0);
        run(32'h7, 32'h0, 3);
        drain("three", 60, 10);

        // Five pulses: saturate at 3, one overflow strobe, four blinks.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_PEND, t+2, 1); ex(EV_PEND, t+3, 2); ex(EV_PEND, t+4, 3);
        ex(EV_LFALL, t+5, 0); ex(EV_OVF, t+5, 0);
        ex(EV_PEND, t+8, 2); ex(EV_LRISE, t+8, 0);
        ex(EV_LFALL, t+12, 0);
        ex(EV_PEND, t+15, 1); ex(EV_LRISE, t+15, 0);
        ex(EV_LFALL, t+19, 0);
        ex(EV_PEND, t+22, 0); ex(EV_LRISE, t+22, 0);
        ex(EV_LFALL, t+26, 0); ex(EV_BFALL, t+29, 0);
        run(32'h1F, 32'h0, 5);
        drain("saturate", 80, 10);

        // pending=1 and a pulse in the last GAP cycle: pending holds at 1.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_PEND, t+2, 1);
        ex(EV_LFALL, t+5, 0);
        ex(EV_LRISE, t+8, 0);
        ex(EV_LFALL, t+12, 0);
        ex(EV_PEND, t+15, 0); ex(EV_LRISE, t+15, 0);
        ex(EV_LFALL, t+19, 0); ex(EV_BFALL, t+22, 0);
        run(32'h83, 32'h0, 8);
        drain("gap_end_pending", 60, 10);

        // pending=0 and a pulse in the last GAP cycle: back-to-back blink, pending stays 0.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_LFALL, t+5, 0);
        ex(EV_LRISE, t+8, 0);
        ex(EV_LFALL, t+12, 0); ex(EV_BFALL, t+15, 0);
        run(32'h81, 32'h0, 8);
        drain("gap_end_empty", 60, 10);

        // Flush during ON with pending=2 and a same-cycle pulse: everything stops.
        @(negedge clk); t = cyc;
        ex(EV_LRISE, t+1, 0); ex(EV_BRISE, t+1, 0);
        ex(EV_PEND, t+2, 1); ex(EV_PEND, t+3, 2);
        ex(EV_PEND, t+4, 0); ex(EV_LFALL, t+4, 0); ex(EV_BFALL, t+4, 0);
        run(32'hF, 32'h8, 4);
        drain("flush", 40, 20);
        chk("flush_final_pending", int'(pending), 0);
        chk("flush_final_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_event_blinker.md
# led_event_blinker

Converts single-cycle internal event pulses (UART byte received, button press, command accepted) into human-visible LED blinks on the board I/O side: one clean pulse in, one fixed-width blink out. It is the output-side counterpart to the input debouncer. Events arriving while a blink is in progress are counted in a saturating pending counter and replayed as separate, distinctly gapped blinks.

## Interface
- `ON_CYCLES`, default 5_000_000 — LED-on duration per blink, in clocks (≥1).
- `OFF_CYCLES`, default 5_000_000 — mandatory LED-off gap after each blink, in clocks (≥1).
- `PEND_W`, default 4 — pending-counter width; max queued events = 2^PEND_W−1.
- `clk`  input  1  — single system clock; all logic on the rising edge.
- `rst`  input  1  — asynchronous, active-low reset.
- `pulse_in`  input  1  — event strobe, synchronous to `clk`; each high cycle is one event.
- `flush`  input  1  — synchronous abort: drop the current blink and all pending events.
- `led_out`  output  1  — registered LED drive, high during the blink on-phase.
- `busy`  output  1  — high in ON or GAP.
- `pending`  output  PEND_W  — queued events not yet started.
- `overflow`  output  1  — one-cycle strobe when an event is dropped because `pending` is saturated.

## Operation
- FSM states: IDLE, ON, GAP. A down-counter timer is sized `$clog2(max(ON_CYCLES, OFF_CYCLES))`, minimum 1 bit.
- Reset (`rst`=0, asynchronous): state IDLE, timer 0, `led_out`=0, `busy`=0, `pending`=0, `overflow`=0.
- Priority per edge: `flush` first, then FSM/counter updates.
- `flush`=1: next state IDLE, `led_out`=0, `pending`=0, `overflow`=0. A `pulse_in` in the same cycle is ignored.
- IDLE with `pulse_in`=1: go to ON and load timer with ON_CYCLES−1. `pending` is unchanged because the event is consumed directly.
- ON: timer decrements each cycle. At timer 0, go to GAP and load OFF_CYCLES−1.
- GAP at timer 0:
  - If `pending`≠0 or `pulse_in`=1: go to ON and consume one event.
  - Otherwise: go to IDLE.
- `pulse_in` in ON or GAP (other than a consuming GAP-end cycle): `pending`+1.
  - If `pending`=2^PEND_W−1, the event is dropped, `overflow`=1 for that cycle, and `pending` holds.
- Simultaneous arrival and consumption at GAP end:
  - `pending`>0 and `pulse_in`=1: `pending` unchanged, no overflow, including when saturated.
  - `pending`=0 and `pulse_in`=1: the pulse starts the next blink and `pending` stays 0.
- `pending` never wraps, and never decrements below 0.
- `led_out` = (state==ON), registered. `busy` = (state≠IDLE), registered.

## Timing
- Latency: a `pulse_in` sampled at edge t drives `led_out` high from edge t, i.e. visible in cycle t+1.
- `led_out` is high for exactly ON_CYCLES clocks, then low for exactly OFF_CYCLES clocks.
- Blink period P = ON_CYCLES+OFF_CYCLES. Queued blinks follow back-to-back with no IDLE cycle in between.
- `busy` falls exactly P clocks after it rises if nothing is pending.
- `overflow` is combinationally derived from registered state plus `pulse_in`, or registered one cycle later. Decision: registered; asserted in the cycle after the dropped event.
- `flush` effect is visible at the next edge. The async `rst` effect is immediate.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2 (P=7, max pending 3).
- Reset mid-blink: assert `rst`=0 in cycle 2 of ON → `led_out`/`busy`/`pending`/`overflow` all 0 immediately. After release, FSM is IDLE, and one pulse gives a normal blink.
- Single pulse at edge t → `led_out`=1 for cycles t+1..t+4 and 0 for t+5..t+7; `busy`=1 for t+1..t+7 and 0 at t+8; `pending` stays 0.
- Pulses on 3 consecutive cycles from IDLE → `pending` goes 1, 2. Three blinks rise at t+1, t+8, t+15, and `pending` reads 1 then 0 at each GAP→ON transition.
- 5 pulses (1 from IDLE + 4 during ON) → `pending` saturates at 3. `overflow` is high exactly one cycle, after the 5th pulse. 4 blinks total.
- `pending`=1 and `pulse_in`=1 in the final GAP cycle → `pending` stays 1, the next ON starts with no gap cycle, and no overflow.
- `flush` during ON with `pending`=2, plus `pulse_in` in the same cycle → next cycle `led_out`=0, `busy`=0, `pending`=0, and no further blinks.
